// File: rtl/pc_control_unit.sv
// Next-PC stage: source mux, PC/EPC registers and a trap sequencer that reads the
// handler address from a vector table. Optional misaligned-target trap: PC_ALIGN_CHECK_EN.
module pc_control_unit #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 5,
  parameter int SEL_W    = 3,
  parameter int RESET_PC = 0,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     exc_req,
  input  logic [1:0]               exc_cause,
  input  logic                     eret,
  input  logic [WIDTH-1:0]         vec_data,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic [WIDTH-1:0]         vec_addr,
  output logic                     vec_rd,
  output logic                     trap_busy,
  output logic                     exc_taken
);

  localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [WIDTH-1:0] VEC_BASE_W = WIDTH'(VEC_BASE);

  typedef enum logic [1:0] {S_RUN, S_VEC_REQ, S_WAIT, S_LOAD} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   pc_next, epc_next, target, new_pc;
  logic [1:0]         cause, cause_next, cause_in;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               load, take_exc;

  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) target = src_bus[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      pc    <= WIDTH'(RESET_PC);
      epc   <= '0;
      cause <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
      cause <= cause_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
    cause_next = cause;
    cnt_next   = cnt;
    load       = pc_write | (pc_write_cond & cond_true);
    new_pc     = eret ? epc : target;
    take_exc   = exc_req;
    cause_in   = exc_cause;
    case (state)
      S_RUN: begin
`ifdef PC_ALIGN_CHECK_EN
        if (!exc_req && (eret || load) && (new_pc[1:0] != 2'b00)) begin
          take_exc = 1'b1;
          cause_in = 2'd3;
        end
`endif
        if (take_exc) begin
          epc_next   = pc - WIDTH'(4);
          cause_next = cause_in;
          state_next = S_VEC_REQ;
        end else if (eret || load) begin
          pc_next = new_pc;
        end
      end
      // WAIT lasts MEM_LAT-1 cycles so LOAD lines up with valid vec_data
      S_VEC_REQ: begin
        cnt_next   = CNT_W'(MEM_LAT - 2);
        state_next = (MEM_LAT == 1) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_next = S_LOAD;
        else           cnt_next   = cnt - 1'b1;
      end
      S_LOAD: begin
        pc_next    = vec_data;
        state_next = S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  assign vec_rd    = (state == S_VEC_REQ);
  assign vec_addr  = vec_rd ? (VEC_BASE_W + WIDTH'(cause)) : '0;
  assign trap_busy = (state != S_RUN);
  assign exc_taken = (state == S_LOAD);

endmodule

// File: tb/tb_pc_control_unit.sv
// Bench for pc_control_unit: cycle-level behavioural model compared every cycle,
// plus directed literal checks on the key scenarios.
module tb_pc_control_unit;
  localparam int W = 32;
  localparam int NS = 5;
  localparam int LAT = 2;
  localparam int VB = 253;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS*W-1:0] src_bus;
  logic [2:0]    sel;
  logic          pc_write, pc_write_cond, cond_true, exc_req, eret;
  logic [1:0]    exc_cause;
  logic [W-1:0]  vec_data;
  logic [W-1:0]  pc, epc, vec_addr;
  logic          vec_rd, trap_busy, exc_taken;

  int passed = 0;
  int total = 0;
  bit checking = 1'b0;

  // model state: k counts cycles since the trap was accepted (0 = not trapping)
  logic [W-1:0] m_pc, m_epc;
  logic [1:0]   m_cause;
  int           k;

  pc_control_unit #(.WIDTH(W), .NUM_SRC(NS), .SEL_W(3), .RESET_PC(0),
                    .VEC_BASE(VB), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .cond_true(cond_true), .exc_req(exc_req),
    .exc_cause(exc_cause), .eret(eret), .vec_data(vec_data), .pc(pc), .epc(epc),
    .vec_addr(vec_addr), .vec_rd(vec_rd), .trap_busy(trap_busy), .exc_taken(exc_taken));

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  always @(posedge clk) begin
    logic [W-1:0] tgt;
    logic         ld, trap;
    logic [1:0]   cs;
    tgt  = eret ? m_epc : ((sel < NS) ? src_bus[sel*W +: W] : '0);
    ld   = eret | pc_write | (pc_write_cond & cond_true);
    trap = exc_req;
    cs   = exc_cause;
`ifdef PC_ALIGN_CHECK_EN
    if (!exc_req && ld && tgt[1:0] != 2'b00) begin trap = 1'b1; cs = 2'd3; end
`endif
    if (reset) begin
      m_pc = '0; m_epc = '0; m_cause = '0; k = 0;
    end else if (k > 0) begin
      if (k == 1 + LAT) begin m_pc = vec_data; k = 0; end
      else k++;
    end else if (trap) begin
      m_epc = m_pc - 32'd4; m_cause = cs; k = 1;
    end else if (ld) begin
      m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check_output("pc", pc, m_pc);
      check_output("epc", epc, m_epc);
      check_output("trap_busy", W'(trap_busy), W'(k != 0));
      check_output("vec_rd", W'(vec_rd), W'(k == 1));
      check_output("vec_addr", vec_addr, (k == 1) ? W'(VB + int'(m_cause)) : '0);
      check_output("exc_taken", W'(exc_taken), W'(k == 1 + LAT));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_ctl();
    pc_write = 0; pc_write_cond = 0; cond_true = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    reset = 1; sel = 0; exc_cause = 0; vec_data = 32'h1F4;
    clear_ctl();
    src_bus = {32'h200, 32'h100, 32'h104, 32'h40, 32'h80};
    step();
    checking = 1'b1;
    step();
    check_output("reset_pc", pc, 32'h0);
    reset = 0;

    sel = 1; pc_write = 1; step(); clear_ctl();
    check_output("load_src1", pc, 32'h40);
    check_output("epc_after_load", epc, 32'h0);
    check_output("busy_after_load", W'(trap_busy), 32'h0);

    sel = 0; pc_write_cond = 1; cond_true = 0; step();
    check_output("cond_false_hold", pc, 32'h40);
    cond_true = 1; step(); clear_ctl();
    check_output("cond_true_load", pc, 32'h80);

    sel = 7; pc_write = 1; step(); clear_ctl();
    check_output("sel_oob_zero", pc, 32'h0);

    sel = 3; pc_write = 1; step(); clear_ctl();
    check_output("load_0x100", pc, 32'h100);
    exc_req = 1; exc_cause = 1; step(); clear_ctl();
    check_output("epc_capture", epc, 32'hFC);
    check_output("vec_rd_pulse", W'(vec_rd), 32'h1);
    check_output("vec_addr_254", vec_addr, 32'd254);
    step();
    check_output("vec_rd_dropped", W'(vec_rd), 32'h0);
    step();
    check_output("exc_taken_pulse", W'(exc_taken), 32'h1);
    step();
    check_output("handler_pc", pc, 32'h1F4);
    check_output("busy_cleared", W'(trap_busy), 32'h0);
    eret = 1; step(); clear_ctl();
    check_output("eret_pc", pc, 32'hFC);

    sel = 4; pc_write = 1; exc_req = 1; exc_cause = 2; step(); clear_ctl();
    check_output("trap_beats_load", pc, 32'hFC);
    check_output("epc_second", epc, 32'hF8);
    step();
    exc_req = 1; exc_cause = 0; pc_write = 1; eret = 1; step(); clear_ctl();
    check_output("nested_epc_kept", epc, 32'hF8);
    step();
    check_output("handler_pc2", pc, 32'h1F4);

    sel = 7; pc_write = 1; step(); clear_ctl();
    exc_req = 1; exc_cause = 0; step(); clear_ctl();
    check_output("epc_wrap", epc, 32'hFFFF_FFFC);
    step();
    reset = 1; step(); reset = 0;
    check_output("reset_in_wait_pc", pc, 32'h0);
    check_output("reset_in_wait_busy", W'(trap_busy), 32'h0);
    check_output("reset_in_wait_taken", W'(exc_taken), 32'h0);
    repeat (4) step();

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
